// File: rtl/nios_key_sw_capture.sv
// Avalon-MM input PIO for the Nios II: synchronises and debounces KEY/SW pins,
// captures key presses in a W1C register and drives a maskable level IRQ.
`timescale 1ns/1ps

module nios_key_sw_capture #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_in,
    input  logic [N_SW-1:0]   sw_in,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);

    localparam int N_IN  = N_KEYS + N_SW;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Keys are active-low, so their idle level is 1; switches idle at 0.
    localparam logic [N_IN-1:0] IDLE = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

    logic [N_IN-1:0]   r_sync1;
    logic [N_IN-1:0]   r_sync2;
    logic [N_IN-1:0]   r_stable;
    logic [CNT_W-1:0]  r_cnt [N_IN];
    logic [N_KEYS-1:0] r_key_prev;
    logic [N_KEYS-1:0] r_edge;
    logic [N_KEYS-1:0] r_mask;

    logic [N_IN-1:0]   w_pins;
    logic [N_KEYS-1:0] w_key_stable;
    logic [N_SW-1:0]   w_sw_stable;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_clr;
    logic [31:0]       w_rd_mux;
    logic              w_unused_wdata;

    assign w_pins       = {sw_in, key_in};
    assign w_key_stable = r_stable[N_KEYS-1:0];
    assign w_sw_stable  = r_stable[N_IN-1:N_KEYS];
    assign w_press      = r_key_prev & ~w_key_stable;
    assign w_clr        = (avs_write && avs_address == 2'd2) ? avs_writedata[N_KEYS-1:0] : '0;
    assign w_unused_wdata = ^avs_writedata[31:N_KEYS];

    // Synchroniser and per-bit debounce: a new level must persist for
    // DEBOUNCE_CYCLES consecutive samples; any return resets the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= IDLE;
            r_sync2  <= IDLE;
            r_stable <= IDLE;
            for (int i = 0; i < N_IN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_pins;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_IN; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            2'd0:    w_rd_mux[N_KEYS-1:0] = ~w_key_stable;
            2'd1:    w_rd_mux[N_SW-1:0]   = w_sw_stable;
            2'd2:    w_rd_mux[N_KEYS-1:0] = r_edge;
            default: w_rd_mux[N_KEYS-1:0] = r_mask;
        endcase
    end

    // Press capture (set beats a same-cycle clear), mask, read port and IRQ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_prev   <= '1;
            r_edge       <= '0;
            r_mask       <= '0;
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            r_key_prev <= w_key_stable;
            r_edge     <= (r_edge & ~w_clr) | w_press;
            if (avs_write && avs_address == 2'd3) begin
                r_mask <= avs_writedata[N_KEYS-1:0];
            end
            if (avs_read) begin
                avs_readdata <= w_rd_mux;
            end
            irq <= |(r_edge & r_mask);
        end
    end

endmodule
